// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) codec front end: codeword bit map,
// result source encodings, slot state and the parity/syndrome helpers.
package hamming_pkg;

  localparam logic SRC_ENC = 1'b0;
  localparam logic SRC_DEC = 1'b1;

  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P4_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic       src;
    logic       err;
    logic [6:0] word;
  } slot_t;

  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    logic [6:0] c;
    c         = '0;
    c[D0_POS] = d[0];
    c[D1_POS] = d[1];
    c[D2_POS] = d[2];
    c[D3_POS] = d[3];
    c[P1_POS] = d[0] ^ d[1] ^ d[3];
    c[P2_POS] = d[0] ^ d[2] ^ d[3];
    c[P4_POS] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  // A nonzero syndrome is the 1-based position of the single flipped bit.
  function automatic logic [2:0] hamming_syndrome(input logic [6:0] c);
    logic [2:0] s;
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    return s;
  endfunction

  function automatic logic [3:0] hamming_extract(input logic [6:0] c);
    return {c[D3_POS], c[D2_POS], c[D1_POS], c[D0_POS]};
  endfunction

endpackage

// File: rtl/hamming74_codec.sv
// Purely combinational Hamming(7,4) encoder plus single-error-correcting
// decoder; both paths are evaluated every cycle and the caller picks one.
module hamming74_codec
  import hamming_pkg::*;
(
  input  logic [3:0] enc_data,
  output logic [6:0] enc_code,
  input  logic [6:0] dec_code,
  output logic [2:0] dec_syn,
  output logic [3:0] dec_data
);

  logic [6:0] flip_mask;
  logic [6:0] fixed_code;

  always_comb begin
    enc_code  = hamming_encode(enc_data);
    dec_syn   = hamming_syndrome(dec_code);
    flip_mask = '0;
    for (int i = 0; i < 7; i++) begin
      flip_mask[i] = (dec_syn == 3'(i + 1));
    end
    fixed_code = dec_code ^ flip_mask;
    dec_data   = hamming_extract(fixed_code);
  end

endmodule

// File: rtl/hamming_codec_arbiter.sv
// Round-robin front end sharing one Hamming(7,4) codec between an encode and a
// decode requester, with a single registered result slot and an error counter.
module hamming_codec_arbiter
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_valid,
  input  logic [3:0]       enc_data,
  output logic             enc_ready,
  input  logic             dec_valid,
  input  logic [6:0]       dec_code,
  output logic             dec_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [6:0]       out_word,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Handshake: a request transfers on a cycle where valid and ready are both
  // high; the result transfers when out_valid and out_ready are both high.
  // ready is the grant and is only raised when the slot frees this cycle.
  slot_state_e      state_q, state_d;
  slot_t            slot_q, slot_d;
  logic             prio_dec_q, prio_dec_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       slot_free;
  logic       grant_enc;
  logic       grant_dec;
  logic [6:0] enc_code;
  logic [2:0] dec_syn;
  logic [3:0] dec_data;
  logic       dec_has_err;

  hamming74_codec u_codec (
    .enc_data (enc_data),
    .enc_code (enc_code),
    .dec_code (dec_code),
    .dec_syn  (dec_syn),
    .dec_data (dec_data)
  );

  assign dec_has_err = (dec_syn != 3'd0);

  // Grants are masked during reset so nothing is accepted while rst is high.
  always_comb begin
    slot_free = (state_q == ST_EMPTY) || out_ready;
    grant_enc = 1'b0;
    grant_dec = 1'b0;
    if (!rst && slot_free) begin
      if (enc_valid && dec_valid) begin
        grant_dec = prio_dec_q;
        grant_enc = !prio_dec_q;
      end else begin
        grant_enc = enc_valid;
        grant_dec = dec_valid;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    prio_dec_d = prio_dec_q;
    err_cnt_d  = err_cnt_q;
    if (grant_enc) begin
      slot_d.src  = SRC_ENC;
      slot_d.err  = 1'b0;
      slot_d.word = enc_code;
      state_d     = ST_FULL;
      prio_dec_d  = 1'b1;
    end else if (grant_dec) begin
      slot_d.src  = SRC_DEC;
      slot_d.err  = dec_has_err;
      slot_d.word = {dec_syn, dec_data};
      state_d     = ST_FULL;
      prio_dec_d  = 1'b0;
      if (dec_has_err && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
    if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      slot_q     <= '0;
      prio_dec_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      prio_dec_q <= prio_dec_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign enc_ready = grant_enc;
  assign dec_ready = grant_dec;
  assign out_valid = (state_q == ST_FULL);
  assign out_src   = slot_q.src;
  assign out_word  = slot_q.word;
  assign out_err   = slot_q.err;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hamming_codec_arbiter.sv
// Directed bench for hamming_codec_arbiter: encode/decode vectors, contention,
// backpressure, counter saturation/clear and asynchronous reset.
module tb_hamming_codec_arbiter;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             enc_valid;
  logic [3:0]       enc_data;
  logic             enc_ready;
  logic             dec_valid;
  logic [6:0]       dec_code;
  logic             dec_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_src;
  logic [6:0]       out_word;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected results as {src, err, word}.
  logic [8:0] exp_q[$];

  logic [3:0] enc_tab[4];
  logic [6:0] enc_exp[4];
  logic [6:0] dec_tab[4];
  logic [6:0] dec_exp[4];

  hamming_codec_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enc_valid (enc_valid),
    .enc_data  (enc_data),
    .enc_ready (enc_ready),
    .dec_valid (dec_valid),
    .dec_code  (dec_code),
    .dec_ready (dec_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .out_word  (out_word),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    enc_valid = 1'b0;
    enc_data  = 4'd0;
    dec_valid = 1'b0;
    dec_code  = 7'd0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [8:0] exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_slot"}, 32'({out_src, out_err, out_word}), 32'(exp));
  endtask

  task automatic sb_check(input string tag);
    logic [8:0] e;
    chk({tag, "_sb_avail"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_out(tag, e);
    end
  endtask

  // Stimulus
  initial begin
    enc_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b1000};
    enc_exp = '{7'h00, 7'h07, 7'h19, 7'h4B};
    dec_tab = '{7'h54, 7'h15, 7'h22, 7'h03};
    dec_exp = '{7'h1B, 7'h7B, 7'h44, 7'h31};

    rst = 1'b1;
    idle_inputs();
    enc_valid = 1'b1;
    dec_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_out_word", 32'(out_word), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_enc_ready", 32'(enc_ready), 32'd0);
    chk("rst_dec_ready", 32'(dec_ready), 32'd0);
    rst = 1'b0;
    idle_inputs();

    // Encode only
    enc_valid = 1'b1;
    enc_data  = 4'b1011;
    #1;
    chk("enc_ready", 32'(enc_ready), 32'd1);
    chk("enc_dec_ready", 32'(dec_ready), 32'd0);
    step();
    check_out("enc_1011", {1'b0, 1'b0, 7'h55});

    // Decode clean, then single-bit error in d1
    enc_valid = 1'b0;
    dec_valid = 1'b1;
    dec_code  = 7'h55;
    #1;
    chk("dec_clean_ready", 32'(dec_ready), 32'd1);
    step();
    check_out("dec_clean", {1'b1, 1'b0, 7'h0B});
    chk("dec_clean_cnt", 32'(err_cnt), 32'd0);
    dec_code = 7'h45;
    #1;
    chk("dec_err_ready", 32'(dec_ready), 32'd1);
    step();
    check_out("dec_err", {1'b1, 1'b1, 7'h5B});
    chk("dec_err_cnt", 32'(err_cnt), 32'd1);

    // Contention: alternate enc, dec starting with enc after reset
    do_reset();
    enc_valid = 1'b1;
    dec_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic exp_enc;
      enc_data = enc_tab[(k + 1) / 2];
      dec_code = dec_tab[k / 2];
      exp_enc  = (k % 2 == 0);
      #1;
      chk($sformatf("cont%0d_enc_ready", k), 32'(enc_ready), 32'(exp_enc));
      chk($sformatf("cont%0d_dec_ready", k), 32'(dec_ready), 32'(!exp_enc));
      chk($sformatf("cont%0d_onehot", k), 32'(enc_ready & dec_ready), 32'd0);
      if (exp_enc) exp_q.push_back({1'b0, 1'b0, enc_exp[k / 2]});
      else         exp_q.push_back({1'b1, 1'b1, dec_exp[k / 2]});
      step();
      sb_check($sformatf("cont%0d", k));
    end
    chk("cont_err_cnt_sat", 32'(err_cnt), 32'd3);

    // Backpressure: slot holds last decode result for 5 cycles
    out_ready = 1'b0;
    enc_data  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_enc_ready", k), 32'(enc_ready), 32'd0);
      chk($sformatf("bp%0d_dec_ready", k), 32'(dec_ready), 32'd0);
      step();
      check_out($sformatf("bp%0d_hold", k), {1'b1, 1'b1, 7'h44});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_enc_ready", 32'(enc_ready), 32'd1);
    chk("bp_release_dec_ready", 32'(dec_ready), 32'd0);
    step();
    check_out("bp_refill", {1'b0, 1'b0, 7'h7F});

    // Counter saturation and clear priority
    do_reset();
    dec_valid = 1'b1;
    dec_code  = 7'h54;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("cnt%0d", i), 32'(err_cnt), 32'((i > 3) ? 3 : i));
      check_out($sformatf("cnt%0d", i), {1'b1, 1'b1, 7'h1B});
    end
    err_clr = 1'b1;
    step();
    chk("cnt_clr_vs_inc", 32'(err_cnt), 32'd0);
    err_clr = 1'b0;
    step();
    chk("cnt_after_clr", 32'(err_cnt), 32'd1);

    // Async reset while FULL and requests pending
    out_ready = 1'b0;
    enc_valid = 1'b1;
    enc_data  = 4'b0010;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_word", 32'(out_word), 32'd0);
    chk("arst_out_src", 32'(out_src), 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_enc_ready", 32'(enc_ready), 32'd0);
    chk("arst_dec_ready", 32'(dec_ready), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_enc_ready", 32'(enc_ready), 32'd1);
    chk("post_rst_dec_ready", 32'(dec_ready), 32'd0);
    step();
    check_out("post_rst_enc", {1'b0, 1'b0, 7'h19});

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hamming_codec_arbiter.md
# hamming_codec_arbiter

Sequential front end that shares one Hamming(7,4) codec between two requesters: an encode stream (4-bit data) and a decode stream (7-bit codewords). Round-robin arbitration chooses one request per cycle, pushes it through the combinational codec, and registers the result in a single output slot with valid/ready flow control. A saturating counter of corrected single-bit errors is kept for status readout. It sits between the chip-level I/O sequencing and the codec datapath.

## Interface
- CNT_W, default 8, width of the corrected-error counter
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- enc_valid  in  1  encode request present
- enc_data  in  4  data nibble to encode
- enc_ready  out  1  encode request accepted this cycle
- dec_valid  in  1  decode request present
- dec_code  in  7  codeword to decode
- dec_ready  out  1  decode request accepted this cycle
- out_valid  out  1  result slot full
- out_ready  in  1  consumer takes result
- out_src  out  1  0 = encode result, 1 = decode result
- out_word  out  7  encode: codeword; decode: {syndrome[2:0], data[3:0]}
- out_err  out  1  decode result had nonzero syndrome (corrected); 0 for encode
- err_cnt  out  CNT_W  corrected-error count, saturating
- err_clr  in  1  synchronous clear of err_cnt

## Operation
- Codeword bit map: c[0]=p1, c[1]=p2, c[2]=d0, c[3]=p4, c[4]=d1, c[5]=d2, c[6]=d3.
- p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
- Syndrome s={c3^c4^c5^c6, c1^c2^c5^c6, c0^c2^c4^c6}; s=0 no error, else flip bit c[s-1], then extract data.
- FSM: EMPTY (out_valid=0), FULL (out_valid=1).
- slot_free = EMPTY, or FULL with out_ready=1 (same-cycle drain and refill allowed).
- Arbiter: at most one grant per cycle, only when slot_free. One valid requester -> grant it. Both valid -> grant the one not granted last; priority pointer updates only on a grant.
- enc_ready/dec_ready are the grant signals; combinational from valids, pointer, state, out_ready. Never both high.
- On grant: slot loads out_src, out_word, out_err; state -> FULL.
- FULL with out_ready=1 and no grant -> EMPTY.
- Requesters must hold valid and data stable until ready; the block does not require this for correctness, it samples on the grant cycle.
- err_cnt increments on each granted decode with s!=0; saturates at 2^CNT_W-1. err_clr has priority: same-cycle clear and increment yields 0.
- Double-bit errors are miscorrected (Hamming(7,4) limit); not detected.

## Timing
- Reset values: out_valid=0, out_src=0, out_word=0, out_err=0, err_cnt=0, priority pointer favours encode, state EMPTY.
- Latency: grant in cycle N -> out_valid=1 with result in cycle N+1.
- Throughput: one result per cycle while out_ready held high.
- out_valid high with out_ready low: out_* held stable, no grants.
- Reset mid-operation: slot contents discarded, counter cleared, pointer restored; no ready asserted while rst high.
- err_cnt updates the cycle after the grant, with the slot load.

## Structure
- Package hamming_pkg: parity equations as functions or masks, codeword bit-position constants, out_src encodings (SRC_ENC=0, SRC_DEC=1), state encoding.
- Sub-module hamming74_codec: purely combinational encode and correct/decode, instantiated once; arbiter, FSM, output slot and counter stay in the top of this block.

## Test plan
- Encode only: enc_data=4'b1011, out_ready=1 -> next cycle out_word=7'h55, out_src=0, out_err=0.
- Decode clean and error: dec_code=7'h55 -> out_word={3'd0,4'b1011}, out_err=0; dec_code=7'h45 -> out_word={3'd5,4'b1011}, out_err=1, err_cnt=1.
- Contention: both valid every cycle, out_ready=1 -> grants alternate enc, dec, enc, dec starting with enc after reset; never both ready.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_* stable, enc_ready=dec_ready=0; out_ready=1 -> drain and new grant same cycle.
- Counter: CNT_W=2, 5 erroneous decodes -> err_cnt saturates at 3; err_clr with concurrent erroneous decode -> 0.
- Async reset asserted while FULL and mid-stream -> outputs zero immediately, first post-reset grant is encode.
